// File: rtl/hazard_stall_controller_pkg.sv
// Shared state encoding and constants for the load-use / cache-miss stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD_WAIT = 2'b01,
    MISS      = 2'b10
  } state_e;

  localparam logic [2:0] DATA_CACHE_LOAD_NONE = 3'b000;

  // Cycles EX must hold so a load sitting in DMk reaches WB before EX proceeds
  localparam int STALL_LEN_DM1 = 3;
  localparam int STALL_LEN_DM2 = 2;
  localparam int STALL_LEN_DM3 = 1;

endpackage

// File: rtl/hazard_stall_controller_load_use_detector.sv
// Combinational load-use check of the EX sources against loads pending in DM1..DM3.
// The youngest matching producer sets the stall length.
module load_use_detector
  import hazard_pkg::*;
#(
  parameter int REG_ADD_WIDTH = 5,
  parameter int D_CACHE_LW_WIDTH = 3,
  parameter logic [D_CACHE_LW_WIDTH-1:0] LOAD_NONE = D_CACHE_LW_WIDTH'(hazard_pkg::DATA_CACHE_LOAD_NONE),
  parameter int CNT_WIDTH = 2
) (
  input  logic [REG_ADD_WIDTH-1:0]    rs1_addr,
  input  logic                        rs1_used,
  input  logic [REG_ADD_WIDTH-1:0]    rs2_addr,
  input  logic                        rs2_used,
  input  logic [REG_ADD_WIDTH-1:0]    rd_addr_dm1,
  input  logic [REG_ADD_WIDTH-1:0]    rd_addr_dm2,
  input  logic [REG_ADD_WIDTH-1:0]    rd_addr_dm3,
  input  logic                        rd_we_dm1,
  input  logic                        rd_we_dm2,
  input  logic                        rd_we_dm3,
  input  logic [D_CACHE_LW_WIDTH-1:0] load_dm1,
  input  logic [D_CACHE_LW_WIDTH-1:0] load_dm2,
  input  logic [D_CACHE_LW_WIDTH-1:0] load_dm3,
  output logic                        hazard_found,
  output logic [CNT_WIDTH-1:0]        stall_len
);

  logic rs1_live, rs2_live;
  logic hit_dm1, hit_dm2, hit_dm3;

  // x0 is hardwired to zero, so it never carries a real dependency
  assign rs1_live = rs1_used && (rs1_addr != '0);
  assign rs2_live = rs2_used && (rs2_addr != '0);

  assign hit_dm1 = rd_we_dm1 && (load_dm1 != LOAD_NONE) &&
                   ((rs1_live && (rs1_addr == rd_addr_dm1)) || (rs2_live && (rs2_addr == rd_addr_dm1)));
  assign hit_dm2 = rd_we_dm2 && (load_dm2 != LOAD_NONE) &&
                   ((rs1_live && (rs1_addr == rd_addr_dm2)) || (rs2_live && (rs2_addr == rd_addr_dm2)));
  assign hit_dm3 = rd_we_dm3 && (load_dm3 != LOAD_NONE) &&
                   ((rs1_live && (rs1_addr == rd_addr_dm3)) || (rs2_live && (rs2_addr == rd_addr_dm3)));

  always_comb begin
    hazard_found = hit_dm1 || hit_dm2 || hit_dm3;
    stall_len    = '0;
    if (hit_dm1) begin
      stall_len = CNT_WIDTH'(STALL_LEN_DM1);
    end else if (hit_dm2) begin
      stall_len = CNT_WIDTH'(STALL_LEN_DM2);
    end else if (hit_dm3) begin
      stall_len = CNT_WIDTH'(STALL_LEN_DM3);
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/bubble sequencer: load-use stalls until the load reaches WB,
// full freeze on data-cache miss, and a saturating stall-cycle counter.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADD_WIDTH = 5,
  parameter int D_CACHE_LW_WIDTH = 3,
  parameter logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_NONE = D_CACHE_LW_WIDTH'(hazard_pkg::DATA_CACHE_LOAD_NONE),
  parameter int CNT_WIDTH = 2,
  parameter int PERF_WIDTH = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [REG_ADD_WIDTH-1:0]    RS1_ADDRESS_EXECUTION,
  input  logic                        RS1_USED_EXECUTION,
  input  logic [REG_ADD_WIDTH-1:0]    RS2_ADDRESS_EXECUTION,
  input  logic                        RS2_USED_EXECUTION,
  input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_DM1,
  input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_DM2,
  input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_DM3,
  input  logic                        RD_WRITE_ENABLE_DM1,
  input  logic                        RD_WRITE_ENABLE_DM2,
  input  logic                        RD_WRITE_ENABLE_DM3,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_DM1,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_DM2,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_DM3,
  input  logic                        DATA_CACHE_READY,
  output logic                        STALL_FETCH,
  output logic                        STALL_DECODE,
  output logic                        STALL_EXECUTION_STAGE,
  output logic                        BUBBLE_DM1,
  output logic                        STALL_MEMORY_STAGES,
  output logic [PERF_WIDTH-1:0]       STALL_CYCLE_COUNT
);

  state_e                 state_q, state_d;
  state_e                 ret_q, ret_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PERF_WIDTH-1:0]  perf_q, perf_d;
  logic                   hazard_found;
  logic [CNT_WIDTH-1:0]   det_len;
  logic                   stall_lu, stall_miss, stall_ex;

  load_use_detector #(
    .REG_ADD_WIDTH    (REG_ADD_WIDTH),
    .D_CACHE_LW_WIDTH (D_CACHE_LW_WIDTH),
    .LOAD_NONE        (DATA_CACHE_LOAD_NONE),
    .CNT_WIDTH        (CNT_WIDTH)
  ) u_detector (
    .rs1_addr     (RS1_ADDRESS_EXECUTION),
    .rs1_used     (RS1_USED_EXECUTION),
    .rs2_addr     (RS2_ADDRESS_EXECUTION),
    .rs2_used     (RS2_USED_EXECUTION),
    .rd_addr_dm1  (RD_ADDRESS_DM1),
    .rd_addr_dm2  (RD_ADDRESS_DM2),
    .rd_addr_dm3  (RD_ADDRESS_DM3),
    .rd_we_dm1    (RD_WRITE_ENABLE_DM1),
    .rd_we_dm2    (RD_WRITE_ENABLE_DM2),
    .rd_we_dm3    (RD_WRITE_ENABLE_DM3),
    .load_dm1     (DATA_CACHE_LOAD_DM1),
    .load_dm2     (DATA_CACHE_LOAD_DM2),
    .load_dm3     (DATA_CACHE_LOAD_DM3),
    .hazard_found (hazard_found),
    .stall_len    (det_len)
  );

  // The detect cycle is already the first stall cycle, so LOAD_WAIT starts
  // with N-2 left and exits on the cycle the countdown reads zero.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    stall_lu   = 1'b0;
    stall_miss = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!DATA_CACHE_READY) begin
          state_d = MISS;
          ret_d   = IDLE;
        end else if (hazard_found) begin
          stall_lu = 1'b1;
          cnt_d    = '0;
          if (det_len > CNT_WIDTH'(1)) begin
            state_d = LOAD_WAIT;
            cnt_d   = det_len - CNT_WIDTH'(2);
          end
        end
      end
      LOAD_WAIT: begin
        stall_lu = 1'b1;
        if (!DATA_CACHE_READY) begin
          state_d = MISS;
          ret_d   = LOAD_WAIT;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      MISS: begin
        stall_miss = 1'b1;
        if (DATA_CACHE_READY) begin
          state_d = ret_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall_ex = stall_lu || stall_miss;

  always_comb begin
    perf_d = perf_q;
    if (stall_ex && (perf_q != '1)) begin
      perf_d = perf_q + PERF_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  // Reset also masks the Mealy path so outputs drop the instant RST rises
  assign STALL_FETCH           = !RST && stall_ex;
  assign STALL_DECODE          = !RST && stall_ex;
  assign STALL_EXECUTION_STAGE = !RST && stall_ex;
  assign BUBBLE_DM1            = !RST && stall_lu;
  assign STALL_MEMORY_STAGES   = !RST && stall_miss;
  assign STALL_CYCLE_COUNT     = perf_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: table of per-cycle vectors plus
// hand-written reset sequences; a 2-bit-counter instance exercises saturation.
module tb_hazard_stall_controller;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic [2:0] ld;
  } stage_t;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    stage_t     dm1;
    stage_t     dm2;
    stage_t     dm3;
    logic       ready;
    logic       exp_stall;
    logic       exp_bubble;
    logic       exp_mem;
    int         exp_cnt;
  } vec_t;

  localparam stage_t NS = '0;

  logic        CLK, RST;
  logic [4:0]  rs1_addr, rs2_addr, rd1, rd2, rd3;
  logic        rs1_used, rs2_used, we1, we2, we3, ready;
  logic [2:0]  ld1, ld2, ld3;
  logic        stall_f, stall_d, stall_e, bubble, stall_m;
  logic [31:0] count;
  logic        sat_f, sat_d, sat_e, sat_b, sat_m;
  logic [1:0]  sat_count;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  hazard_stall_controller dut (
    .CLK(CLK), .RST(RST),
    .RS1_ADDRESS_EXECUTION(rs1_addr), .RS1_USED_EXECUTION(rs1_used),
    .RS2_ADDRESS_EXECUTION(rs2_addr), .RS2_USED_EXECUTION(rs2_used),
    .RD_ADDRESS_DM1(rd1), .RD_ADDRESS_DM2(rd2), .RD_ADDRESS_DM3(rd3),
    .RD_WRITE_ENABLE_DM1(we1), .RD_WRITE_ENABLE_DM2(we2), .RD_WRITE_ENABLE_DM3(we3),
    .DATA_CACHE_LOAD_DM1(ld1), .DATA_CACHE_LOAD_DM2(ld2), .DATA_CACHE_LOAD_DM3(ld3),
    .DATA_CACHE_READY(ready),
    .STALL_FETCH(stall_f), .STALL_DECODE(stall_d), .STALL_EXECUTION_STAGE(stall_e),
    .BUBBLE_DM1(bubble), .STALL_MEMORY_STAGES(stall_m), .STALL_CYCLE_COUNT(count)
  );

  hazard_stall_controller #(.PERF_WIDTH(2)) dut_sat (
    .CLK(CLK), .RST(RST),
    .RS1_ADDRESS_EXECUTION(rs1_addr), .RS1_USED_EXECUTION(rs1_used),
    .RS2_ADDRESS_EXECUTION(rs2_addr), .RS2_USED_EXECUTION(rs2_used),
    .RD_ADDRESS_DM1(rd1), .RD_ADDRESS_DM2(rd2), .RD_ADDRESS_DM3(rd3),
    .RD_WRITE_ENABLE_DM1(we1), .RD_WRITE_ENABLE_DM2(we2), .RD_WRITE_ENABLE_DM3(we3),
    .DATA_CACHE_LOAD_DM1(ld1), .DATA_CACHE_LOAD_DM2(ld2), .DATA_CACHE_LOAD_DM3(ld3),
    .DATA_CACHE_READY(ready),
    .STALL_FETCH(sat_f), .STALL_DECODE(sat_d), .STALL_EXECUTION_STAGE(sat_e),
    .BUBBLE_DM1(sat_b), .STALL_MEMORY_STAGES(sat_m), .STALL_CYCLE_COUNT(sat_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic stage_t ld(input int rd);
    stage_t s;
    s.rd = 5'(rd);
    s.we = 1'b1;
    s.ld = 3'b010;
    return s;
  endfunction

  function automatic stage_t ld_nowe(input int rd);
    stage_t s;
    s = ld(rd);
    s.we = 1'b0;
    return s;
  endfunction

  function automatic stage_t alu(input int rd);
    stage_t s;
    s.rd = 5'(rd);
    s.we = 1'b1;
    s.ld = 3'b000;
    return s;
  endfunction

  function automatic vec_t mk(input string name, input int r1, input bit u1, input int r2, input bit u2,
                              input stage_t d1, input stage_t d2, input stage_t d3, input bit rdy,
                              input bit s, input bit b, input bit m, input int cnt);
    vec_t v;
    v.name = name; v.rs1 = 5'(r1); v.u1 = u1; v.rs2 = 5'(r2); v.u2 = u2;
    v.dm1 = d1; v.dm2 = d2; v.dm3 = d3; v.ready = rdy;
    v.exp_stall = s; v.exp_bubble = b; v.exp_mem = m; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    rs1_addr = v.rs1; rs1_used = v.u1; rs2_addr = v.rs2; rs2_used = v.u2;
    rd1 = v.dm1.rd; we1 = v.dm1.we; ld1 = v.dm1.ld;
    rd2 = v.dm2.rd; we2 = v.dm2.we; ld2 = v.dm2.ld;
    rd3 = v.dm3.rd; we3 = v.dm3.we; ld3 = v.dm3.ld;
    ready = v.ready;
  endtask

  task automatic check_val(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s/%s: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic s, input logic b, input logic m, input int cnt);
    check_val(name, "stall_fetch", 32'(stall_f), 32'(s));
    check_val(name, "stall_decode", 32'(stall_d), 32'(s));
    check_val(name, "stall_ex", 32'(stall_e), 32'(s));
    check_val(name, "bubble", 32'(bubble), 32'(b));
    check_val(name, "stall_mem", 32'(stall_m), 32'(m));
    check_val(name, "count", count, 32'(cnt));
    check_val(name, "sat_outputs", 32'({sat_f, sat_d, sat_e, sat_b, sat_m}), 32'({s, s, s, b, m}));
    check_val(name, "sat_count", 32'(sat_count), 32'((cnt > 3) ? 3 : cnt));
  endtask

  initial begin
    // load-use from DM1: exactly three stall cycles while the load walks to WB
    vecs.push_back(mk("dm1_c0",      5,1, 0,0, ld(5), NS, NS, 1, 1,1,0, 0));
    vecs.push_back(mk("dm1_c1",      5,1, 0,0, NS, ld(5), NS, 1, 1,1,0, 1));
    vecs.push_back(mk("dm1_c2",      5,1, 0,0, NS, NS, ld(5), 1, 1,1,0, 2));
    vecs.push_back(mk("dm1_done",    5,1, 0,0, NS, NS, NS,    1, 0,0,0, 3));
    vecs.push_back(mk("dm3_rs2",     0,0, 7,1, NS, NS, ld(7), 1, 1,1,0, 3));
    vecs.push_back(mk("dm3_done",    0,0, 7,1, NS, NS, NS,    1, 0,0,0, 4));
    vecs.push_back(mk("rd_zero",     0,1, 0,0, ld(0), NS, NS, 1, 0,0,0, 4));
    vecs.push_back(mk("alu_write",   9,1, 0,0, alu(9), NS, NS, 1, 0,0,0, 4));
    vecs.push_back(mk("rs2_unused",  0,0,12,0, NS, ld(12), NS, 1, 0,0,0, 4));
    vecs.push_back(mk("we_low",      3,1, 0,0, ld_nowe(3), NS, NS, 1, 0,0,0, 4));
    // DM1 and DM3 both match: the DM1 producer dictates three cycles
    vecs.push_back(mk("multi_c0",    4,1, 6,1, ld(6), NS, ld(4), 1, 1,1,0, 4));
    vecs.push_back(mk("multi_c1",    4,1, 6,1, NS, ld(6), NS, 1, 1,1,0, 5));
    vecs.push_back(mk("multi_c2",    4,1, 6,1, NS, NS, ld(6), 1, 1,1,0, 6));
    vecs.push_back(mk("multi_done",  4,1, 6,1, NS, NS, NS,    1, 0,0,0, 7));
    vecs.push_back(mk("dm2_c0",      8,1, 0,0, NS, ld(8), NS, 1, 1,1,0, 7));
    vecs.push_back(mk("dm2_c1",      8,1, 0,0, NS, NS, ld(8), 1, 1,1,0, 8));
    vecs.push_back(mk("dm2_done",    8,1, 0,0, NS, NS, NS,    1, 0,0,0, 9));
    // back-to-back dependent loads: six contiguous stall cycles
    vecs.push_back(mk("b2b_c0",     10,1, 0,0, ld(10), NS, NS, 1, 1,1,0, 9));
    vecs.push_back(mk("b2b_c1",     10,1, 0,0, NS, ld(10), NS, 1, 1,1,0, 10));
    vecs.push_back(mk("b2b_c2",     10,1, 0,0, NS, NS, ld(10), 1, 1,1,0, 11));
    vecs.push_back(mk("b2b_c3",     11,1, 0,0, ld(11), NS, NS, 1, 1,1,0, 12));
    vecs.push_back(mk("b2b_c4",     11,1, 0,0, NS, ld(11), NS, 1, 1,1,0, 13));
    vecs.push_back(mk("b2b_c5",     11,1, 0,0, NS, NS, ld(11), 1, 1,1,0, 14));
    vecs.push_back(mk("b2b_done",   11,1, 0,0, NS, NS, NS,     1, 0,0,0, 15));
    // miss during LOAD_WAIT (countdown 1): four frozen cycles, then two more stall cycles
    vecs.push_back(mk("miss_c0",    13,1, 0,0, ld(13), NS, NS, 1, 1,1,0, 15));
    vecs.push_back(mk("miss_c1",    13,1, 0,0, NS, ld(13), NS, 0, 1,1,0, 16));
    vecs.push_back(mk("miss_c2",    13,1, 0,0, NS, ld(13), NS, 0, 1,0,1, 17));
    vecs.push_back(mk("miss_c3",    13,1, 0,0, NS, ld(13), NS, 0, 1,0,1, 18));
    vecs.push_back(mk("miss_c4",    13,1, 0,0, NS, ld(13), NS, 0, 1,0,1, 19));
    vecs.push_back(mk("miss_c5",    13,1, 0,0, NS, ld(13), NS, 1, 1,0,1, 20));
    vecs.push_back(mk("miss_c6",    13,1, 0,0, NS, NS, ld(13), 1, 1,1,0, 21));
    vecs.push_back(mk("miss_c7",    13,1, 0,0, NS, NS, NS,     1, 1,1,0, 22));
    vecs.push_back(mk("miss_done",  13,1, 0,0, NS, NS, NS,     1, 0,0,0, 23));
    // not-ready in IDLE wins over a hazard; detection resumes after the freeze
    vecs.push_back(mk("idle_miss",  14,1, 0,0, ld(14), NS, NS, 0, 0,0,0, 23));
    vecs.push_back(mk("idle_frz",   14,1, 0,0, ld(14), NS, NS, 1, 1,0,1, 23));
    vecs.push_back(mk("idle_det",   14,1, 0,0, ld(14), NS, NS, 1, 1,1,0, 24));
    vecs.push_back(mk("idle_c1",    14,1, 0,0, NS, ld(14), NS, 1, 1,1,0, 25));
    vecs.push_back(mk("idle_c2",    14,1, 0,0, NS, NS, ld(14), 1, 1,1,0, 26));
    vecs.push_back(mk("idle_done",  14,1, 0,0, NS, NS, NS,     1, 0,0,0, 27));

    // reset held with a hazard on the inputs: outputs must stay low
    RST = 1'b1;
    apply_stimulus(mk("rst", 5,1, 0,0, ld(5), NS, NS, 1, 0,0,0, 0));
    @(negedge CLK);
    check_output("reset_hold", 0, 0, 0, 0);
    @(posedge CLK); #1;
    apply_stimulus(mk("idle", 0,0, 0,0, NS, NS, NS, 1, 0,0,0, 0));
    RST = 1'b0;
    @(negedge CLK);
    check_output("post_reset", 0, 0, 0, 0);
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      @(negedge CLK);
      check_output(vecs[i].name, vecs[i].exp_stall, vecs[i].exp_bubble, vecs[i].exp_mem, vecs[i].exp_cnt);
      @(posedge CLK); #1;
    end

    // asynchronous reset in the middle of LOAD_WAIT
    apply_stimulus(mk("rlw", 15,1, 0,0, ld(15), NS, NS, 1, 0,0,0, 0));
    @(negedge CLK);
    check_output("rst_lw_det", 1, 1, 0, 27);
    @(posedge CLK); #1;
    apply_stimulus(mk("rlw", 15,1, 0,0, NS, ld(15), NS, 1, 0,0,0, 0));
    @(negedge CLK);
    check_output("rst_lw_wait", 1, 1, 0, 28);
    #1 RST = 1'b1;
    #1 check_output("rst_lw_async", 0, 0, 0, 0);
    @(posedge CLK); #1;
    apply_stimulus(mk("idle", 0,0, 0,0, NS, NS, NS, 1, 0,0,0, 0));
    RST = 1'b0;
    @(negedge CLK);
    check_output("rst_lw_release", 0, 0, 0, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_output("rst_lw_idle", 0, 0, 0, 0);
    @(posedge CLK); #1;

    // asynchronous reset in the middle of MISS
    apply_stimulus(mk("rmiss", 0,0, 0,0, NS, NS, NS, 0, 0,0,0, 0));
    @(negedge CLK);
    check_output("rst_miss_idle", 0, 0, 0, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_output("rst_miss_frz", 1, 0, 1, 0);
    #1 RST = 1'b1;
    #1 check_output("rst_miss_async", 0, 0, 0, 0);
    @(posedge CLK); #1;
    apply_stimulus(mk("idle", 0,0, 0,0, NS, NS, NS, 1, 0,0,0, 0));
    RST = 1'b0;
    @(negedge CLK);
    check_output("rst_miss_release", 0, 0, 0, 0);
    @(posedge CLK); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
